prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/clkdiv_pkg.sv | 5 +
 rtl/prog_clock_divider_if.sv | 18 +
 rtl/clkdiv_fsm.sv | 56 +++++
 rtl/prog_clock_divider.sv | 80 ++++++++
 tb/tb_prog_clock_divider.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider.
package clkdiv_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/prog_clock_divider_if.sv
// Run control, divisor handshake and divided-clock outputs of prog_clock_divider.
// period_count exists only when CLKDIV_PERIOD_CNT_EN is defined.
interface prog_clock_divider_if #(parameter int WIDTH = 16);
  logic             en;
  logic [WIDTH-1:0] div;
  logic             div_valid;
  logic             div_ready;
  logic             new_clock;
  logic             tick;
`ifdef CLKDIV_PERIOD_CNT_EN
  logic [WIDTH-1:0] period_count;
  modport master (output en, div, div_valid, input div_ready, new_clock, tick, period_count);
  modport slave  (input en, div, div_valid, output div_ready, new_clock, tick, period_count);
`else
  modport master (output en, div, div_valid, input div_ready, new_clock, tick);
  modport slave  (input en, div, div_valid, output div_ready, new_clock, tick);
`endif
endinterface

// File: rtl/clkdiv_fsm.sv
// IDLE/HIGH/LOW sequencer; registers new_clock and tick, flags phase transitions to the datapath.
module clkdiv_fsm
  import clkdiv_pkg::*;
(
  input  logic clock,
  input  logic reset_L,
  input  logic en,
  input  logic cnt_zero,
  output logic new_clock,
  output logic tick,
  output logic enter_high,
  output logic to_low,
  output logic period_end
);
  state_t state, state_nxt;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      new_clock <= 1'b0;
      tick      <= 1'b0;
    end else begin
      state     <= state_nxt;
      new_clock <= (state_nxt == HIGH);
      tick      <= enter_high;
    end
  end

  always_comb begin
    state_nxt  = state;
    enter_high = 1'b0;
    to_low     = 1'b0;
    period_end = 1'b0;
    case (state)
      IDLE: if (en) begin
        state_nxt  = HIGH;
        enter_high = 1'b1;
      end
      HIGH: if (cnt_zero) begin
        state_nxt = LOW;
        to_low    = 1'b1;
      end
      LOW: if (cnt_zero) begin
        // en is only sampled here, so a stop always finishes the low phase
        period_end = 1'b1;
        if (en) begin
          state_nxt  = HIGH;
          enter_high = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/prog_clock_divider.sv
// Programmable clock divider: phase counter, pending/active divisor and valid/ready update.
// Optional period counter enabled by CLKDIV_PERIOD_CNT_EN.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 3975
) (
  input logic                  clock,
  input logic                  reset_L,
  prog_clock_divider_if.slave  bus
);
  localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] act_div, pend_div, cnt;
  logic [WIDTH-1:0] eff_div, start_n, start_hi, run_n, run_hi, run_lo;
  logic             pend_full, xfer;
  logic             enter_high, to_low, period_end;

  assign xfer          = bus.div_valid & ~pend_full;
  assign bus.div_ready = ~pend_full;

  // A pending divisor takes effect on the very HIGH entry that consumes it
  assign eff_div  = pend_full ? pend_div : act_div;
  assign start_n  = (eff_div < MIN_N) ? MIN_N : eff_div;
  assign start_hi = start_n >> 1;
  assign run_n    = (act_div < MIN_N) ? MIN_N : act_div;
  assign run_hi   = run_n >> 1;
  assign run_lo   = run_n - run_hi;

  clkdiv_fsm u_fsm (
    .clock      (clock),
    .reset_L    (reset_L),
    .en         (bus.en),
    .cnt_zero   (cnt == '0),
    .new_clock  (bus.new_clock),
    .tick       (bus.tick),
    .enter_high (enter_high),
    .to_low     (to_low),
    .period_end (period_end)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      cnt <= '0;
    end else if (enter_high) begin
      cnt <= start_hi - ONE;
    end else if (to_low) begin
      cnt <= run_lo - ONE;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  // Capture and consume are mutually exclusive: capture needs pending empty
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      act_div   <= WIDTH'(DEFAULT_DIV);
      pend_div  <= '0;
      pend_full <= 1'b0;
    end else if (enter_high && pend_full) begin
      act_div   <= pend_div;
      pend_full <= 1'b0;
    end else if (xfer) begin
      pend_div  <= bus.div;
      pend_full <= 1'b1;
    end
  end

`ifdef CLKDIV_PERIOD_CNT_EN
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)        bus.period_count <= '0;
    else if (period_end) bus.period_count <= bus.period_count + ONE;
  end
`else
  logic unused_period_end;
  assign unused_period_end = period_end;
`endif
endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench: each period is modelled as a queue of H ones then L zeros.
// Checks period_count when CLKDIV_PERIOD_CNT_EN is defined.
module tb_prog_clock_divider;
  localparam int W    = 16;
  localparam int DDIV = 4;

  logic clock   = 1'b0;
  logic reset_L = 1'b0;
  always #5 clock = ~clock;

  prog_clock_divider_if #(.WIDTH(W)) bus ();
  prog_clock_divider #(.WIDTH(W), .DEFAULT_DIV(DDIV)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_act, m_pend, m_cnt;
  bit m_full, m_inper, m_clk, m_tick;
  bit q[$];

  task automatic model_reset();
    m_act = DDIV; m_pend = 0; m_full = 0; q.delete();
    m_inper = 0; m_clk = 0; m_tick = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit xfer;
    int n;
    xfer   = bus.div_valid && !m_full;
    m_tick = 0;
    if (q.size() == 0) begin
      if (m_inper) m_cnt = (m_cnt + 1) % (1 << W);
      m_inper = 0;
      if (bus.en) begin
        n = m_full ? m_pend : m_act;
        if (m_full) begin m_act = m_pend; m_full = 0; end
        if (n < 2) n = 2;
        for (int i = 0; i < n; i++) q.push_back(i < n / 2);
        m_inper = 1;
        m_tick  = 1;
      end
    end
    m_clk = (q.size() != 0) ? q.pop_front() : 1'b0;
    if (xfer) begin m_full = 1; m_pend = int'(bus.div); end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("new_clock", 32'(bus.new_clock), 32'(m_clk));
    chk("tick",      32'(bus.tick),      32'(m_tick));
    chk("div_ready", 32'(bus.div_ready), 32'(!m_full));
`ifdef CLKDIV_PERIOD_CNT_EN
    chk("period_count", 32'(bus.period_count), 32'(m_cnt));
`endif
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outs();
  endtask

  task automatic send(int d);
    bus.div       = W'(d);
    bus.div_valid = 1'b1;
    cyc();
    bus.div_valid = 1'b0;
  endtask

  task automatic wait_tick(string tag);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      cyc();
      if (m_tick) found = 1;
    end
    chk(tag, 32'(found), 32'(1));
  endtask

  initial begin
    bit found;
    bus.en = 1'b0; bus.div = '0; bus.div_valid = 1'b0;
    model_reset();
    #12;
    check_outs();
    @(negedge clock);
    reset_L = 1'b1;

    // Default divisor 4: 1,1,0,0 with tick on first high cycle
    bus.en = 1'b1;
    repeat (12) cyc();

    // Stop, load 5 while idle, restart
    bus.en = 1'b0;
    repeat (6) cyc();
    send(5);
    bus.en = 1'b1;
    repeat (12) cyc();

    // Degenerate divisors clamp to 2
    send(0);
    repeat (8) cyc();
    send(1);
    repeat (8) cyc();

    // N=8, drop en on the second high cycle
    send(8);
    wait_tick("wait_tick_a");
    wait_tick("wait_tick_b");
    cyc();
    bus.en = 1'b0;
    repeat (12) cyc();
    chk("idle_clock", 32'(bus.new_clock), 32'(0));

    // Second offer while pending is full must wait for div_ready
    bus.en = 1'b1;
    send(6);
    bus.div       = W'(10);
    bus.div_valid = 1'b1;
    repeat (24) cyc();
    bus.div_valid = 1'b0;
    repeat (12) cyc();

    // Randomized run
    for (int i = 0; i < 300; i++) begin
      bus.en        = ($urandom_range(0, 7) != 0);
      bus.div_valid = ($urandom_range(0, 3) == 0);
      bus.div       = W'($urandom_range(0, 12));
      cyc();
    end
    bus.div_valid = 1'b0;

    // Asynchronous reset in the middle of a low phase
    bus.en = 1'b1;
    found  = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      cyc();
      if (!m_clk && q.size() != 0) found = 1;
    end
    chk("wait_low", 32'(found), 32'(1));
    #2 reset_L = 1'b0;
    #1 model_reset();
    check_outs();
    @(negedge clock);
    reset_L = 1'b1;
    check_outs();
    repeat (14) cyc();
`ifdef CLKDIV_PERIOD_CNT_EN
    chk("three_periods", 32'(bus.period_count), 32'(3));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
